// File: rtl/prm_edge_mask_accum.sv
// rtl/prm_edge_mask_accum.sv - collects checker edge masks per frame and drains the bitmap as words
// Optional blocked-edge count output enabled by defining PRM_EDGE_CNT_EN.
module prm_edge_mask_accum #(
  parameter int NUM_EDGES = 512,
  parameter int CODE_W    = 15,
  parameter int OUT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 obs_valid,
  output logic                 obs_ready,
  input  logic [CODE_W-1:0]    obs_code,
  input  logic                 obs_last,
  output logic [CODE_W-1:0]    chk_code,
  input  logic [NUM_EDGES-1:0] chk_mask,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic                 out_last,
  output logic                 busy
`ifdef PRM_EDGE_CNT_EN
  ,
  output logic [$clog2(NUM_EDGES+1)-1:0] blk_count
`endif
);

  localparam int NUM_WORDS = NUM_EDGES / OUT_W;
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [1:0] {COLLECT, FLUSH, DRAIN} state_t;

  state_t                          state_q, state_d;
  logic [NUM_WORDS-1:0][OUT_W-1:0] acc_q;
  logic [IDX_W-1:0]                word_idx_q;
  logic                            pend_q;
  logic                            accept;
  logic                            out_fire;
  logic                            last_word;

  always_ff @(posedge clk) begin
    if (rst) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    obs_ready = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      COLLECT: begin
        obs_ready = 1'b1;
        if (obs_valid && obs_last) state_d = FLUSH;
      end
      FLUSH: state_d = DRAIN;
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && last_word) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  assign accept    = obs_valid & obs_ready;
  assign out_fire  = out_valid & out_ready;
  assign last_word = (word_idx_q == IDX_W'(NUM_WORDS - 1));
  assign out_data  = acc_q[word_idx_q];
  assign out_last  = out_valid & last_word;
  assign busy      = (state_q != COLLECT) | pend_q;

  // The mask returned for the code loaded last cycle is folded in while the next code loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      chk_code   <= '0;
      pend_q     <= 1'b0;
      word_idx_q <= '0;
    end else begin
      pend_q <= accept;
      if (accept) chk_code <= obs_code;
      if (pend_q) acc_q <= acc_q | chk_mask;
      if (state_q == FLUSH) word_idx_q <= '0;
      if (out_fire) begin
        if (last_word) begin
          acc_q      <= '0;
          word_idx_q <= '0;
        end else begin
          word_idx_q <= word_idx_q + IDX_W'(1);
        end
      end
    end
  end

`ifdef PRM_EDGE_CNT_EN
  localparam int CNT_W = $clog2(NUM_EDGES + 1);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                    cnt_q <= '0;
    else if (state_q == FLUSH)  cnt_q <= '0;
    else if (out_fire)          cnt_q <= cnt_q + CNT_W'($countones(out_data));
  end

  assign blk_count = cnt_q;
`endif

endmodule

// File: tb/tb_prm_edge_mask_accum.sv
// tb/tb_prm_edge_mask_accum.sv - directed self-checking bench for prm_edge_mask_accum
module tb_prm_edge_mask_accum;

  localparam int NUM_EDGES = 64;
  localparam int CODE_W    = 15;
  localparam int OUT_W     = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 obs_valid;
  logic                 obs_ready;
  logic [CODE_W-1:0]    obs_code;
  logic                 obs_last;
  logic [CODE_W-1:0]    chk_code;
  logic [NUM_EDGES-1:0] chk_mask;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_W-1:0]     out_data;
  logic                 out_last;
  logic                 busy;
`ifdef PRM_EDGE_CNT_EN
  logic [$clog2(NUM_EDGES+1)-1:0] blk_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Checker model: edge i is blocked when the low six code bits equal i.
  assign chk_mask = 64'd1 << chk_code[5:0];

  prm_edge_mask_accum #(
    .NUM_EDGES(NUM_EDGES),
    .CODE_W(CODE_W),
    .OUT_W(OUT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .obs_valid(obs_valid),
    .obs_ready(obs_ready),
    .obs_code(obs_code),
    .obs_last(obs_last),
    .chk_code(chk_code),
    .chk_mask(chk_mask),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .busy(busy)
`ifdef PRM_EDGE_CNT_EN
    ,
    .blk_count(blk_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int codes[$]);
    foreach (codes[i]) begin
      obs_valid = 1'b1;
      obs_code  = CODE_W'(codes[i]);
      obs_last  = (i == codes.size() - 1);
      step();
    end
    obs_valid = 1'b0;
    obs_last  = 1'b0;
    check("flush_no_valid", out_valid, 1'b0);
    check("flush_not_ready", obs_ready, 1'b0);
    step();
    check("drain_latency", out_valid, 1'b1);
  endtask

  task automatic get_word(input string tag, input logic [31:0] exp_data, input logic exp_last);
    int n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_data"}, out_data, exp_data);
    check({tag, "_last"}, out_last, exp_last);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    obs_valid = 1'b0;
    obs_code  = '0;
    obs_last  = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;

    check("rst_obs_ready", obs_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_chk_code", chk_code, 15'd0);
`ifdef PRM_EDGE_CNT_EN
    check("rst_blk_count", blk_count, 0);
`endif

    // Codes 3,40,3 then a 5-cycle stall on the first drained word.
    send_frame('{3, 40, 3});
    for (int c = 0; c < 5; c++) begin
      obs_valid = c[0];
      obs_code  = 15'd10;
      obs_last  = 1'b1;
      check("stall_data", out_data, 32'h0000_0008);
      check("stall_last", out_last, 1'b0);
      check("stall_valid", out_valid, 1'b1);
      check("stall_obs_ready", obs_ready, 1'b0);
      step();
    end
    obs_valid = 1'b0;
    obs_last  = 1'b0;
    check("stall_chk_code", chk_code, 15'd3);
    get_word("f1_w0", 32'h0000_0008, 1'b0);
    get_word("f1_w1", 32'h0000_0100, 1'b1);
    check("f1_done_valid", out_valid, 1'b0);
    check("f1_done_ready", obs_ready, 1'b1);
    check("f1_done_busy", busy, 1'b0);

    // Single-code frame; must carry no residue from the previous frame.
    send_frame('{63});
    get_word("f2_w0", 32'h0000_0000, 1'b0);
    get_word("f2_w1", 32'h8000_0000, 1'b1);

    // Reset in the middle of a drain discards the partial bitmap.
    send_frame('{5});
    get_word("f3_w0", 32'h0000_0020, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_ready", obs_ready, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_chk_code", chk_code, 15'd0);
    send_frame('{0});
    get_word("f4_w0", 32'h0000_0001, 1'b0);
    get_word("f4_w1", 32'h0000_0000, 1'b1);

`ifdef PRM_EDGE_CNT_EN
    send_frame('{0, 1, 2, 33});
    get_word("f5_w0", 32'h0000_0007, 1'b0);
    get_word("f5_w1", 32'h0000_0002, 1'b1);
    check("f5_blk_count", blk_count, 4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
